reg4_capture: RTL

Response-capture block for the 4-bit register path: samples a register's true output `q` and complement output `q0` on a strobe, checks that `q0 == ~q`, and buffers each sample with its check result in a 16-entry FIFO. A host drains the buffer through a valid/ready read port. Sits at the output end of the register under test; a vector source drives the register's inputs, and this block captures and checks its outputs.

---
 rtl/reg4_pkg.sv | 23 ++
 rtl/reg4_cap_fifo.sv | 68 ++++++
 rtl/reg4_capture.sv | 87 ++++++++
 3 files changed

// File: rtl/reg4_pkg.sv
// Shared types and sizing for the 4-bit register response-capture path.
package reg4_pkg;

  localparam int W       = 4;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * W + 1;

  localparam logic [3:0] ERR_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // High when the complement output is not the exact inverse of the true output.
  function automatic logic compl_err(input logic [W-1:0] q_v, input logic [W-1:0] q0_v);
    return (q0_v != ~q_v);
  endfunction

endpackage

// File: rtl/reg4_cap_fifo.sv
// Capture buffer: DEPTH-entry circular store with an extra count bit to tell full from empty.
module reg4_cap_fifo
  import reg4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               wr_ok_s;
  logic               rd_ok_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign wr_ok_s = wr_en_i && !full_o && !clr_i;
  assign rd_ok_s = rd_en_i && (count_q != {CNT_W{1'b0}}) && !clr_i;

  // Occupancy next-state; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (wr_ok_s && !rd_ok_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok_s && !wr_ok_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
      if (clr_i) begin
        wr_ptr_q <= {PTR_W{1'b0}};
        rd_ptr_q <= {PTR_W{1'b0}};
      end else begin
        if (wr_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (rd_ok_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Entry storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : {ENTRY_W{1'b0}};
  assign count_o   = count_q;

endmodule

// File: rtl/reg4_capture.sv
// Samples q/q0 of the register under test, flags broken complements and buffers
// {err, q, q0} for a host reading through a valid/ready port.
module reg4_capture
  import reg4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               cap_en,
  input  logic [W-1:0]       q,
  input  logic [W-1:0]       q0,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic [3:0]         err_cnt,
  output logic               ovf,
  output logic               busy
);

  state_e     state_q;
  logic [3:0] err_cnt_q;
  logic       ovf_q;

  logic       clr_s;
  logic       wr_en_s;
  logic       rd_en_s;
  logic       sample_err_s;
  logic       last_slot_s;

  assign sample_err_s = compl_err(q, q0);
  assign clr_s        = (state_q == ST_IDLE) && start;
  assign wr_en_s      = (state_q == ST_CAPT) && cap_en && !full;
  assign rd_en_s      = rd_valid && rd_ready && !clr_s;
  // A push that is not offset by a pop fills the last free slot.
  assign last_slot_s  = wr_en_s && !rd_en_s && (count == CNT_W'(DEPTH - 1));

  reg4_cap_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr_s),
    .wr_en_i   (wr_en_s),
    .wr_data_i ({sample_err_s, q, q0}),
    .rd_en_i   (rd_en_s),
    .rd_data_o (rd_data),
    .count_o   (count),
    .full_o    (full)
  );

  // Run-control FSM with the saturating error counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= 4'd0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_CAPT;
            err_cnt_q <= 4'd0;
            ovf_q     <= 1'b0;
          end
        end
        ST_CAPT: begin
          if (wr_en_s && sample_err_s && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + 4'd1;
          end
          if (stop || last_slot_s) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (cap_en) ovf_q <= 1'b1;
          if (count == {CNT_W{1'b0}}) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid = (count != {CNT_W{1'b0}});
  assign err_cnt  = err_cnt_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
